ps2_cmd_seq: RTL and testbench
==============================

PS2_CMD_SEQ -- requirements
Module: ps2_cmd_seq

Interface
REQ-001 SHALL have parameter pClkFreq, default 40000000, system clock frequency in Hz.
REQ-002 SHALL have parameter pTimeoutMs, default 20, per-phase response timeout in ms.
REQ-003 SHALL have parameter pRetries, default 3, maximum resends per command byte after 0xFE.
REQ-004 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid_i  input  1  host command byte valid.
REQ-007 SHALL have port cmd_data_i  input  8  host command byte.
REQ-008 SHALL have port cmd_ready_o  output  1  command queue not full.
REQ-009 SHALL have port tx_start_o  output  1  one-cycle pulse: load tx_data_o into the keyboard transmitter.
REQ-010 SHALL have port tx_data_o  output  8  byte to transmit.
REQ-011 SHALL have port tx_clear_o  output  1  one-cycle pulse: abort transmitter (status write 0xFF).
REQ-012 SHALL have port tx_done_i  input  1  transmit complete (1 = idle/complete).
REQ-013 SHALL have port rx_valid_i  input  1  received byte pending.
REQ-014 SHALL have port rx_data_i  input  8  received byte.
REQ-015 SHALL have port rx_perr_i  input  1  parity error on pending byte.
REQ-016 SHALL have port rx_clear_o  output  1  one-cycle pulse: release receive register (status write 0x00).
REQ-017 SHALL have port scan_valid_o  output  1  forwarded scan byte valid.
REQ-018 SHALL have port scan_data_o  output  8  forwarded scan byte.
REQ-019 SHALL have port scan_ready_i  input  1  host accepts scan byte.
REQ-020 SHALL have port err_o  output  1  sticky error flag.
REQ-021 SHALL have port err_code_o  output  2  0 none, 1 timeout, 2 resend exhausted, 3 parity.
REQ-022 SHALL have port err_clr_i  input  1  clears err_o/err_code_o.

Function
REQ-023 SHALL queue commands in a 4-entry FIFO; push when cmd_valid_i & cmd_ready_o; cmd_ready_o = not full; head popped only on 0xFA or error.
REQ-024 SHALL implement states IDLE, SEND, WAIT_TX, WAIT_RESP, FAIL.
REQ-025 IDLE -> SEND when queue non-empty and no receive byte pending; rx bytes in IDLE go to scan path.
REQ-026 SEND: pulse tx_start_o with tx_data_o = head, reload timer, -> WAIT_TX next cycle.
REQ-027 WAIT_TX: must observe tx_done_i=0 then tx_done_i=1 -> WAIT_RESP with timer reloaded; timeout -> pulse tx_clear_o, code 1, -> FAIL.
REQ-028 WAIT_RESP, rx 0xFA: pulse rx_clear_o, pop head, clear retry count, -> IDLE.
REQ-029 WAIT_RESP, rx 0xFE: pulse rx_clear_o; retry count < pRetries -> increment, -> SEND; else code 2, -> FAIL.
REQ-030 Any other rx byte (any state): forwarded to scan path, state and timer unaffected.
REQ-031 Scan path: one-entry register; capture + rx_clear_o pulse only when empty; when full rx left pending (keyboard inhibited); scan_valid_o drops cycle after scan_valid_o & scan_ready_i.
REQ-032 rx_valid_i & rx_perr_i: pulse rx_clear_o, discard byte, set code 3, no state change.
REQ-033 After any rx_clear_o pulse rx_valid_i SHALL be ignored for 2 cycles.
REQ-034 Timer: down-counter of pClkFreq/1000*pTimeoutMs cycles; expiry in WAIT_RESP -> code 1, -> FAIL.
REQ-035 FAIL: pop head, clear retry count, set err_o, -> IDLE next cycle; newer error overwrites code; err_clr_i in same cycle as a new error loses.

Reset
REQ-036 On rst_ni=0 immediately: state IDLE, queue empty, cmd_ready_o=1, all pulses 0, tx_data_o=0, scan_valid_o=0, scan_data_o=0, err_o=0, err_code_o=0.
REQ-037 Reset mid-transfer SHALL NOT issue tx_clear_o; downstream reset handles transmitter.

Configuration
REQ-038 With PS2SEQ_RETRY_EN defined, 0xFE resends per REQ-029.
REQ-039 Without PS2SEQ_RETRY_EN, 0xFE goes straight to FAIL with code 2; pRetries unused, no retry counter.

Structure
REQ-040 Package ps2seq_pkg SHALL hold state enum, error-code enum, constants PS2_ACK=0xFA, PS2_RESEND=0xFE, queue depth 4.
REQ-041 Command FIFO SHALL be sub-module ps2seq_cmdq; timer and FSM in top.

Verification
REQ-042 Push 0xED,0x02; model answers 0xFA each -> two tx_start_o pulses with 0xED then 0x02, queue empty, err_o=0.
REQ-043 Push 0xF4; answer 0xFE,0xFE,0xFA -> three transmits of 0xF4, no error; with 0xFE x4 -> err_code_o=2 after 4 transmits.
REQ-044 Push 0xFF; no response -> after pTimeoutMs err_code_o=1, head popped, IDLE.
REQ-045 Keyboard sends 0x1C in WAIT_RESP with scan_ready_i=0 -> scan_valid_o=1 data 0x1C; second 0x32 held with rx_clear_o low until first accepted.
REQ-046 Push 5 commands while stalled -> cmd_ready_o=0 after 4th; assert rst_ni=0 mid-WAIT_TX -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/ps2seq_pkg.sv
// ---------------------------------------------------------------------------
// ps2seq_pkg -- shared types and constants for the PS/2 command sequencer.
//   state_e    : sequencer FSM states
//   err_e      : error codes reported on err_code_o
//   PS2_ACK / PS2_RESEND : keyboard response bytes with protocol meaning
//   CMDQ_DEPTH : command queue depth
//   timeout_cycles() : converts clock frequency and milliseconds to cycles
// ---------------------------------------------------------------------------
package ps2seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_TX   = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_RESEND  = 2'd2,
        ERR_PARITY  = 2'd3
    } err_e;

    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;

    localparam int unsigned CMDQ_DEPTH  = 32'd4;
    localparam int unsigned CMDQ_AW     = 32'd2;
    // Occupancy value meaning "full", sized to the occupancy counter.
    localparam logic [2:0]  CMDQ_FULL_CNT = 3'd4;

    // Number of clock cycles in a timeout window; never less than one.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned ms);
        int unsigned cyc;
        cyc = (clk_hz / 32'd1000) * ms;
        if (cyc == 32'd0) begin
            cyc = 32'd1;
        end else begin
            cyc = cyc;
        end
        return cyc;
    endfunction

endpackage

// File: rtl/ps2seq_cmdq.sv
// ---------------------------------------------------------------------------
// ps2seq_cmdq -- 4-entry command byte FIFO for the PS/2 sequencer.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i, data_i : write request and byte (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head byte
//   empty_o/full_o : occupancy flags
// ---------------------------------------------------------------------------
module ps2seq_cmdq
    import ps2seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);

    logic [7:0]         r_mem [CMDQ_DEPTH];
    logic [CMDQ_AW-1:0] r_wr_ptr;
    logic [CMDQ_AW-1:0] r_rd_ptr;
    logic [CMDQ_AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == CMDQ_FULL_CNT);
    assign empty_o = (r_count == 3'd0);
    assign head_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // Storage, pointers and occupancy; pointers wrap naturally at depth 4.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CMDQ_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_cmd_seq.sv
// ---------------------------------------------------------------------------
// ps2_cmd_seq -- PS/2 keyboard command sequencer.
// Queues host command bytes, sends each to the keyboard transmitter, waits for
// transmit completion and the keyboard's ACK (0xFA), handles RESEND (0xFE),
// per-phase timeouts and receive parity errors. Non-protocol received bytes
// are forwarded through a one-entry scan register.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_data_i/cmd_ready_o : host command push interface
//   tx_start_o/tx_data_o/tx_clear_o/tx_done_i : keyboard transmitter control
//   rx_valid_i/rx_data_i/rx_perr_i/rx_clear_o : keyboard receive register
//   scan_valid_o/scan_data_o/scan_ready_i     : forwarded scan bytes
//   err_o/err_code_o/err_clr_i    : sticky error flag and code
// Build option: define PS2SEQ_RETRY_EN to resend a command on 0xFE up to
// pRetries times; without it 0xFE fails the command immediately.
// ---------------------------------------------------------------------------
module ps2_cmd_seq
    import ps2seq_pkg::*;
#(
    parameter int unsigned pClkFreq   = 40000000,
    parameter int unsigned pTimeoutMs = 20,
    parameter int unsigned pRetries   = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       tx_clear_o,
    input  logic       tx_done_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_perr_i,
    output logic       rx_clear_o,
    output logic       scan_valid_o,
    output logic [7:0] scan_data_o,
    input  logic       scan_ready_i,
    output logic       err_o,
    output logic [1:0] err_code_o,
    input  logic       err_clr_i
);

    localparam int unsigned LP_TMO_CYC  = timeout_cycles(pClkFreq, pTimeoutMs);
    localparam int unsigned LP_TMR_W    = (LP_TMO_CYC < 32'd2) ? 32'd1 : $clog2(LP_TMO_CYC + 32'd1);
    localparam logic [LP_TMR_W-1:0] LP_TMR_LOAD = LP_TMR_W'(LP_TMO_CYC - 32'd1);

    // Registers
    state_e              r_state;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_tx_clear;
    logic                r_rx_clear;
    logic [1:0]          r_rx_ign;
    logic [LP_TMR_W-1:0] r_timer;
    logic                r_seen_busy;
    logic                r_scan_valid;
    logic [7:0]          r_scan_data;
    logic                r_err;
    err_e                r_err_code;

    // Combinational
    state_e     w_state_nxt;
    logic       w_tx_start_nxt;
    logic [7:0] w_tx_data_nxt;
    logic       w_tx_clear_nxt;
    logic       w_rx_clear_nxt;
    logic       w_tmr_load;
    logic       w_tmo;
    logic       w_seen_nxt;
    logic       w_pop;
    logic       w_fsm_err;
    err_e       w_fsm_code;
    logic       w_err_set;
    err_e       w_err_code_nxt;
    logic       w_q_empty;
    logic       w_q_full;
    logic [7:0] w_q_head;
    logic       w_rx_evt;
    logic       w_rx_perr;
    logic       w_rx_ack;
    logic       w_rx_rsnd;
    logic       w_rx_fwd;
    logic       w_scan_cap;

`ifdef PS2SEQ_RETRY_EN
    localparam int unsigned LP_RTY_W = (pRetries < 32'd2) ? 32'd1 : $clog2(pRetries + 32'd1);
    localparam logic [LP_RTY_W-1:0] LP_RTY_MAX = LP_RTY_W'(pRetries);
    logic [LP_RTY_W-1:0] r_retry;
    logic                w_retry_inc;
    logic                w_retry_clr;
`else
    logic w_unused_retry;
    assign w_unused_retry = (pRetries == 32'd0);
`endif

    ps2seq_cmdq u_cmdq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .data_i  (cmd_data_i),
        .pop_i   (w_pop),
        .head_o  (w_q_head),
        .empty_o (w_q_empty),
        .full_o  (w_q_full)
    );

    assign cmd_ready_o  = ~w_q_full;
    assign tx_start_o   = r_tx_start;
    assign tx_data_o    = r_tx_data;
    assign tx_clear_o   = r_tx_clear;
    assign rx_clear_o   = r_rx_clear;
    assign scan_valid_o = r_scan_valid;
    assign scan_data_o  = r_scan_data;
    assign err_o        = r_err;
    assign err_code_o   = r_err_code;

    // A pending byte is only looked at once the post-clear blanking is over,
    // so the stale byte still visible right after our clear is not reused.
    assign w_rx_evt   = rx_valid_i & (r_rx_ign == 2'd0);
    assign w_rx_perr  = w_rx_evt & rx_perr_i;
    assign w_rx_ack   = w_rx_evt & ~rx_perr_i & (r_state == ST_WAIT_RESP) & (rx_data_i == PS2_ACK);
    assign w_rx_rsnd  = w_rx_evt & ~rx_perr_i & (r_state == ST_WAIT_RESP) & (rx_data_i == PS2_RESEND);
    assign w_rx_fwd   = w_rx_evt & ~rx_perr_i & ~w_rx_ack & ~w_rx_rsnd;
    // A full scan register leaves the byte pending, which inhibits the keyboard.
    assign w_scan_cap = w_rx_fwd & ~r_scan_valid;
    assign w_tmo      = (r_timer == {LP_TMR_W{1'b0}});

    // Next-state and command-side control decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_tx_clear_nxt = 1'b0;
        w_tmr_load     = 1'b0;
        w_seen_nxt     = r_seen_busy;
        w_pop          = 1'b0;
        w_fsm_err      = 1'b0;
        w_fsm_code     = ERR_NONE;
`ifdef PS2SEQ_RETRY_EN
        w_retry_inc    = 1'b0;
        w_retry_clr    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_q_empty && !rx_valid_i) begin
                    w_state_nxt    = ST_SEND;
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = w_q_head;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_tmr_load  = 1'b1;
                w_seen_nxt  = 1'b0;
                w_state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // Completion needs a busy phase first so a still-idle
                // transmitter is not mistaken for a finished one.
                if (r_seen_busy && tx_done_i) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ST_WAIT_RESP;
                end else if (w_tmo) begin
                    w_tx_clear_nxt = 1'b1;
                    w_fsm_err      = 1'b1;
                    w_fsm_code     = ERR_TIMEOUT;
                    w_state_nxt    = ST_FAIL;
                end else if (!tx_done_i) begin
                    w_seen_nxt     = 1'b1;
                end else begin
                    w_seen_nxt     = r_seen_busy;
                end
            end
            ST_WAIT_RESP: begin
                if (w_rx_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
`ifdef PS2SEQ_RETRY_EN
                    w_retry_clr = 1'b1;
`endif
                end else if (w_rx_rsnd) begin
`ifdef PS2SEQ_RETRY_EN
                    if (r_retry < LP_RTY_MAX) begin
                        w_retry_inc    = 1'b1;
                        w_tx_start_nxt = 1'b1;
                        w_tx_data_nxt  = w_q_head;
                        w_state_nxt    = ST_SEND;
                    end else begin
                        w_fsm_err      = 1'b1;
                        w_fsm_code     = ERR_RESEND;
                        w_state_nxt    = ST_FAIL;
                    end
`else
                    w_fsm_err   = 1'b1;
                    w_fsm_code  = ERR_RESEND;
                    w_state_nxt = ST_FAIL;
`endif
                end else if (w_tmo) begin
                    w_fsm_err   = 1'b1;
                    w_fsm_code  = ERR_TIMEOUT;
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_state_nxt = ST_WAIT_RESP;
                end
            end
            ST_FAIL: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_IDLE;
`ifdef PS2SEQ_RETRY_EN
                w_retry_clr = 1'b1;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Receive release and error update; a sequencing error in the same cycle
    // as a parity error is the one reported.
    always_comb begin
        w_rx_clear_nxt = w_rx_perr | w_rx_ack | w_rx_rsnd | w_scan_cap;
        w_err_set      = w_fsm_err | w_rx_perr;
        if (w_fsm_err) begin
            w_err_code_nxt = w_fsm_code;
        end else begin
            w_err_code_nxt = ERR_PARITY;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered transmitter/receiver handshakes, timer and busy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_clear  <= 1'b0;
            r_rx_clear  <= 1'b0;
            r_rx_ign    <= 2'd0;
            r_timer     <= LP_TMR_LOAD;
            r_seen_busy <= 1'b0;
        end else begin
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_clear  <= w_tx_clear_nxt;
            r_rx_clear  <= w_rx_clear_nxt;
            r_seen_busy <= w_seen_nxt;
            // Blank the pulse cycle plus the two cycles after it.
            if (w_rx_clear_nxt) begin
                r_rx_ign <= 2'd3;
            end else if (r_rx_ign != 2'd0) begin
                r_rx_ign <= r_rx_ign - 2'd1;
            end
            if (w_tmr_load) begin
                r_timer <= LP_TMR_LOAD;
            end else if (!w_tmo) begin
                r_timer <= r_timer - {{(LP_TMR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // One-entry scan byte register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scan_valid <= 1'b0;
            r_scan_data  <= 8'h00;
        end else if (r_scan_valid && scan_ready_i) begin
            r_scan_valid <= 1'b0;
        end else if (w_scan_cap) begin
            r_scan_valid <= 1'b1;
            r_scan_data  <= rx_data_i;
        end
    end

    // Sticky error flag; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_err_set) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code_nxt;
        end else if (err_clr_i) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end
    end

`ifdef PS2SEQ_RETRY_EN
    // Resend counter for the current head command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retry <= {LP_RTY_W{1'b0}};
        end else if (w_retry_clr) begin
            r_retry <= {LP_RTY_W{1'b0}};
        end else if (w_retry_inc) begin
            r_retry <= r_retry + {{(LP_RTY_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_ps2_cmd_seq -- directed self-checking bench for ps2_cmd_seq.
// The bench plays both the keyboard transmitter (tx_done_i handshake) and
// the keyboard itself (rx bytes). Timeout is shortened to 200 cycles via
// parameters (100 kHz clock, 2 ms).
// ---------------------------------------------------------------------------
module tb_ps2_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic [7:0] cmd_data_i = 8'h00;
    logic       cmd_ready_o;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       tx_clear_o;
    logic       tx_done_i = 1'b1;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_perr_i = 1'b0;
    logic       rx_clear_o;
    logic       scan_valid_o;
    logic [7:0] scan_data_o;
    logic       scan_ready_i = 1'b0;
    logic       err_o;
    logic [1:0] err_code_o;
    logic       err_clr_i = 1'b0;

    int total = 0;
    int bad = 0;
    int tx_cnt = 0;
    int txc_cnt = 0;
    int rxc_cnt = 0;

    ps2_cmd_seq #(
        .pClkFreq   (100000),
        .pTimeoutMs (2),
        .pRetries   (3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_ready_o  (cmd_ready_o),
        .tx_start_o   (tx_start_o),
        .tx_data_o    (tx_data_o),
        .tx_clear_o   (tx_clear_o),
        .tx_done_i    (tx_done_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_perr_i    (rx_perr_i),
        .rx_clear_o   (rx_clear_o),
        .scan_valid_o (scan_valid_o),
        .scan_data_o  (scan_data_o),
        .scan_ready_i (scan_ready_i),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 clk = ~clk;

    // Pulse counters used for "how many times did it happen" expectations.
    always @(posedge clk) begin
        if (tx_start_o) tx_cnt <= tx_cnt + 1;
        if (tx_clear_o) txc_cnt <= txc_cnt + 1;
        if (rx_clear_o) rxc_cnt <= rxc_cnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        tick(1);
        cmd_valid_i = 1'b0;
    endtask

    // Wait for a transmit start, check its byte, then act as the transmitter.
    task automatic expect_tx(input string tag, input logic [7:0] d);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start_o) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        check({tag, "_data"}, 32'(tx_data_o), 32'(d));
        tx_done_i = 1'b0;
        tick(3);
        tx_done_i = 1'b1;
        tick(1);
    endtask

    // Present a keyboard byte and wait for the sequencer to release it.
    task automatic send_rx(input string tag, input logic [7:0] d, input logic pe);
        logic ok;
        ok = 1'b0;
        rx_valid_i = 1'b1;
        rx_data_i  = d;
        rx_perr_i  = pe;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rx_clear_o) begin
                ok = 1'b1;
                break;
            end
        end
        rx_valid_i = 1'b0;
        rx_perr_i  = 1'b0;
        check({tag, "_rxclr"}, 32'(ok), 32'd1);
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;
        int cnt;
        logic hit;

        // ---- reset values ----
        #1;
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_pulses", 32'({tx_start_o, tx_clear_o, rx_clear_o}), 32'd0);
        check("rst_txdata", 32'(tx_data_o), 32'd0);
        check("rst_scan", 32'({scan_valid_o, scan_data_o}), 32'd0);
        check("rst_err", 32'({err_o, err_code_o}), 32'd0);
        tick(2);
        rst_ni = 1'b1;
        tick(2);

        // ---- two commands, each ACKed ----
        c0 = tx_cnt;
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'hED;
        tick(1);
        cmd_data_i  = 8'h02;
        tick(1);
        cmd_valid_i = 1'b0;
        expect_tx("ed", 8'hED);
        send_rx("ed_ack", 8'hFA, 1'b0);
        expect_tx("p02", 8'h02);
        send_rx("p02_ack", 8'hFA, 1'b0);
        tick(20);
        check("ack2_txcnt", 32'(tx_cnt - c0), 32'd2);
        check("ack2_err", 32'(err_o), 32'd0);
        check("ack2_ready", 32'(cmd_ready_o), 32'd1);

        // ---- resend handling ----
        c0 = tx_cnt;
        push(8'hF4);
        expect_tx("f4a", 8'hF4);
        send_rx("f4a_rsnd", 8'hFE, 1'b0);
`ifdef PS2SEQ_RETRY_EN
        expect_tx("f4b", 8'hF4);
        send_rx("f4b_rsnd", 8'hFE, 1'b0);
        expect_tx("f4c", 8'hF4);
        send_rx("f4c_ack", 8'hFA, 1'b0);
        tick(10);
        check("rsnd_txcnt", 32'(tx_cnt - c0), 32'd3);
        check("rsnd_err", 32'(err_o), 32'd0);
        c0 = tx_cnt;
        push(8'hF4);
        for (int i = 0; i < 4; i++) begin
            expect_tx("f4x", 8'hF4);
            send_rx("f4x_rsnd", 8'hFE, 1'b0);
        end
        tick(2);
        check("exh_txcnt", 32'(tx_cnt - c0), 32'd4);
        check("exh_err", 32'({err_o, err_code_o}), 32'h6);
`else
        tick(2);
        check("rsnd_txcnt", 32'(tx_cnt - c0), 32'd1);
        check("rsnd_err", 32'({err_o, err_code_o}), 32'h6);
`endif
        clear_err();
        check("errclr", 32'({err_o, err_code_o}), 32'd0);
        tick(10);

        // ---- response timeout ----
        c0 = tx_cnt;
        push(8'hFF);
        expect_tx("ff", 8'hFF);
        cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (err_o) begin
                hit = 1'b1;
                break;
            end
            tick(1);
            cnt++;
        end
        check("rtmo_seen", 32'(hit), 32'd1);
        check("rtmo_window", 32'((cnt >= 195) && (cnt <= 205)), 32'd1);
        check("rtmo_code", 32'(err_code_o), 32'd1);
        tick(20);
        check("rtmo_popped", 32'(tx_cnt - c0), 32'd1);
        clear_err();

        // ---- transmit timeout (transmitter never goes busy) ----
        c1 = txc_cnt;
        push(8'hF2);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_clear_o) begin
                hit = 1'b1;
                break;
            end
            tick(1);
        end
        check("ttmo_clr", 32'(hit), 32'd1);
        check("ttmo_code", 32'({err_o, err_code_o}), 32'h5);
        tick(2);
        check("ttmo_clrcnt", 32'(txc_cnt - c1), 32'd1);
        clear_err();
        tick(5);

        // ---- scan forwarding with back-pressure during WAIT_RESP ----
        c0 = tx_cnt;
        push(8'hF0);
        expect_tx("f0", 8'hF0);
        send_rx("s1c", 8'h1C, 1'b0);
        check("s1c_valid", 32'(scan_valid_o), 32'd1);
        check("s1c_data", 32'(scan_data_o), 32'h1C);
        tick(4);
        c1 = rxc_cnt;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h32;
        tick(8);
        check("s32_held", 32'(rxc_cnt - c1), 32'd0);
        check("s32_olddata", 32'(scan_data_o), 32'h1C);
        scan_ready_i = 1'b1;
        tick(1);
        scan_ready_i = 1'b0;
        check("s1c_drop", 32'(scan_valid_o), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (rx_clear_o) begin
                hit = 1'b1;
                break;
            end
        end
        rx_valid_i = 1'b0;
        check("s32_clr", 32'(hit), 32'd1);
        check("s32_scan", 32'({scan_valid_o, scan_data_o}), 32'h132);
        tick(3);
        send_rx("f0_ack", 8'hFA, 1'b0);
        scan_ready_i = 1'b1;
        tick(1);
        scan_ready_i = 1'b0;
        tick(10);
        check("scan_txcnt", 32'(tx_cnt - c0), 32'd1);
        check("scan_err", 32'(err_o), 32'd0);

        // ---- parity error while idle ----
        send_rx("par", 8'h55, 1'b1);
        check("par_err", 32'({err_o, err_code_o}), 32'h7);
        check("par_noscan", 32'(scan_valid_o), 32'd0);
        clear_err();
        tick(5);

        // ---- queue full while stalled, then reset mid-transfer ----
        c0 = tx_cnt;
        c1 = txc_cnt;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("q3_ready", 32'(cmd_ready_o), 32'd1);
        push(8'h44);
        check("q4_ready", 32'(cmd_ready_o), 32'd0);
        push(8'h55);
        check("q5_ready", 32'(cmd_ready_o), 32'd0);
        tick(3);
        rst_ni = 1'b0;
        #1;
        check("mrst_ready", 32'(cmd_ready_o), 32'd1);
        check("mrst_pulses", 32'({tx_start_o, tx_clear_o, rx_clear_o}), 32'd0);
        check("mrst_txdata", 32'(tx_data_o), 32'd0);
        check("mrst_scan_err", 32'({scan_valid_o, err_o, err_code_o}), 32'd0);
        tick(2);
        rst_ni = 1'b1;
        tick(30);
        check("mrst_txcnt", 32'(tx_cnt - c0), 32'd1);
        check("mrst_noclr", 32'(txc_cnt - c1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
